pipeline_control: RTL and testbench
===================================

# pipeline_control

Central stall/flush sequencer for the five-stage RV32I pipeline. Drives `load` and `buffer_sel` of the four inter-stage buffers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register enable/select. It resolves data-memory stalls, instruction-fetch stalls, load-use hazards and branch mispredict recovery. It also tracks one in-flight stale instruction fetch across a redirect.

## Interface
Parameters:
- none.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `imem_resp`  in  1  instruction fetch data valid this cycle.
- `imem_pending`  in  1  fetch outstanding and not completing this cycle.
- `dmem_stall`  in  1  MEM-stage data access not finished.
- `ex_valid`  in  1  EX-stage packet valid.
- `ex_mispredict`  in  1  EX computed next_pc differs from predicted next_pc.
- `idex_is_load`  in  1  ID/EX packet is a valid load.
- `idex_rd`  in  5  ID/EX destination register.
- `ifid_rs1`, `ifid_rs2`  in  5 each  source registers decoded from the IF/ID packet.
- `ifid_uses_rs1`, `ifid_uses_rs2`  in  1 each  source register is actually read.
- `ifid_load`, `idex_load`, `exmem_load`, `memwb_load`  out  1 each  buffer load enables.
- `ifid_sel`, `idex_sel`, `exmem_sel`, `memwb_sel`  out  `buffer_load_mux::buffer_sel_t`  buffer merge selects.
- `pc_load`  out  1  PC register enable.
- `pc_redirect`  out  1  PC takes the EX-resolved target (1) or the predicted PC (0).

## Operation
- Normal (RUN, no events): all loads are 1. Selects are `load_ifid`, `load_idex`, `load_exmem` and `load_memwb`. `pc_load` = `imem_resp`. `pc_redirect` = 0.
- Events are resolved in the following priority order, combinationally within the cycle.
- 1. `dmem_stall`: all buffer loads are 0 and `pc_load` is 0. The whole pipeline freezes. Lower-priority events are re-evaluated next cycle.
- 2. Mispredict (`ex_valid & ex_mispredict`, RUN only):
  - `ifid_sel` and `idex_sel` are `load_invalid`, with loads at 1.
  - EX/MEM and MEM/WB advance normally.
  - `pc_load` = 1 and `pc_redirect` = 1.
  - If `imem_pending` is 1, the next state is DISCARD. Otherwise the state stays RUN.
  - An `imem_resp` arriving in the same cycle is wrong-path and is dropped by the IF/ID invalidation.
- 3. Load-use: `idex_is_load` & `idex_rd` != 0 & ((`ifid_uses_rs1` & `rs1` == `rd`) | (`ifid_uses_rs2` & `rs2` == `rd`)).
  - `ifid_load` = 0 (holds), `pc_load` = 0.
  - `idex_sel` is `load_invalid`, creating a bubble.
  - EX/MEM and MEM/WB advance.
  - Lasts exactly one cycle because the load leaves ID/EX.
- 4. Fetch stall (`!imem_resp`): `ifid_sel` is `load_invalid`, creating a bubble. Downstream stages advance and `pc_load` is 0.
- DISCARD state:
  - `ifid_sel` is `load_invalid` and `pc_load` = 0 every cycle.
  - Downstream stages behave as in RUN subject to `dmem_stall`.
  - On `imem_resp`, the response is dropped and the next state is RUN. This applies even while `dmem_stall` is 1.
  - Mispredict and load-use are ignored in DISCARD because ID/EX and EX contents are bubbles.
- FSM states (enum `pipe_ctrl_state_t`): RUN and DISCARD only.

## Timing
- Every output is a combinational function of the state and the current inputs. The state register updates on `posedge clk`.
- Reset: when `rst` = 1, all loads are 0, all selects are `use_old`, and `pc_load` and `pc_redirect` are 0. The state is RUN on the next cycle. Reset mid-DISCARD returns to RUN and the stale response is forgotten; the memory side is reset in the same cycle.
- Mispredict penalty: 2 bubbles when no fetch is outstanding. Otherwise it is 2 plus the number of cycles until the stale `imem_resp`.
- Load-use penalty: exactly 1 bubble.
- `dmem_stall` during the mispredict cycle: redirect is deferred. EX inputs stay frozen, so the mispredict re-asserts on the first unstalled cycle.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - Adds outputs `stall_cycles` (32 bits) and `flush_count` (32 bits). Both reset to 0 and wrap modulo 2^32.
  - `stall_cycles` increments on every cycle where `dmem_stall` is 1 or the load-use condition holds.
  - `flush_count` increments once per honored mispredict.
- `PIPE_CTRL_PERF_EN` undefined: no counters and no such ports.

## Structure
- Package `pipe_ctrl_types`: `pipe_ctrl_state_t`. It reuses the existing `buffer_load_mux::buffer_sel_t`.
- Sub-module `hazard_detect`: combinational load-use comparator with output `load_use`. All remaining logic lives in `pipeline_control`.

## Test plan
- Idle: `imem_resp` = 1, no hazards → all loads 1, selects `load_ifid`/`load_idex`/`load_exmem`/`load_memwb`, `pc_load` = 1.
- Load-use: `idex_is_load` = 1, `idex_rd` = 5, `ifid_rs2` = 5, `uses_rs2` = 1 → `ifid_load` = 0, `idex_sel` = `load_invalid`, `pc_load` = 0 for 1 cycle. Repeat with `rd` = 0 → no stall.
- Mispredict with `imem_pending` = 1:
  - Cycle 0: `ifid_sel` and `idex_sel` = `load_invalid`, `pc_redirect` = 1.
  - Next 3 cycles in DISCARD: `pc_load` = 0.
  - `imem_resp` in cycle 4 is dropped.
  - Cycle 5 is RUN.
- `dmem_stall` = 1 together with mispredict and load-use for 3 cycles → all loads 0 for 3 cycles, then the mispredict is honored in cycle 4.
- `rst` asserted in DISCARD → outputs go to their reset values and the state is RUN on the next cycle. With `PIPE_CTRL_PERF_EN`, 2 mispredicts and 4 stall cycles give `flush_count` = 2 and `stall_cycles` = 4.

Source files
------------

// File: rtl/pipeline_control_pkg.sv
// Shared types for the pipeline stall/flush sequencer: buffer merge selects and
// the sequencer state encoding.
package buffer_load_mux;
    typedef enum logic [2:0] {
        use_old      = 3'd0,
        load_ifid    = 3'd1,
        load_idex    = 3'd2,
        load_exmem   = 3'd3,
        load_memwb   = 3'd4,
        load_invalid = 3'd5
    } buffer_sel_t;
endpackage

package pipe_ctrl_types;
    typedef enum logic {
        RUN     = 1'b0,
        DISCARD = 1'b1
    } pipe_ctrl_state_t;
endpackage

// File: rtl/pipeline_control_hazard_detect.sv
// Load-use comparator: the ID/EX load writes a register the IF/ID packet reads.
module hazard_detect (
    input  logic       idex_is_load,
    input  logic [4:0] idex_rd,
    input  logic [4:0] ifid_rs1,
    input  logic [4:0] ifid_rs2,
    input  logic       ifid_uses_rs1,
    input  logic       ifid_uses_rs2,
    output logic       load_use
);
    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = ifid_uses_rs1 && (ifid_rs1 == idex_rd);
    assign rs2_hit  = ifid_uses_rs2 && (ifid_rs2 == idex_rd);
    // x0 is never a real destination, so it can never create a dependency.
    assign load_use = idex_is_load && (idex_rd != 5'd0) && (rs1_hit || rs2_hit);
endmodule

// File: rtl/pipeline_control.sv
// Stall/flush sequencer for the five-stage pipeline buffers and PC.
// Optional PIPE_CTRL_PERF_EN adds stall_cycles / flush_count counters.
//   state   | meaning
//   RUN     | normal operation, events resolved by priority
//   DISCARD | redirected; waiting to drop one stale wrong-path fetch response
module pipeline_control
    import buffer_load_mux::*;
    import pipe_ctrl_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_resp,
    input  logic        imem_pending,
    input  logic        dmem_stall,
    input  logic        ex_valid,
    input  logic        ex_mispredict,
    input  logic        idex_is_load,
    input  logic [4:0]  idex_rd,
    input  logic [4:0]  ifid_rs1,
    input  logic [4:0]  ifid_rs2,
    input  logic        ifid_uses_rs1,
    input  logic        ifid_uses_rs2,
    output logic        ifid_load,
    output logic        idex_load,
    output logic        exmem_load,
    output logic        memwb_load,
    output buffer_sel_t ifid_sel,
    output buffer_sel_t idex_sel,
    output buffer_sel_t exmem_sel,
    output buffer_sel_t memwb_sel,
    output logic        pc_load,
    output logic        pc_redirect
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);
    pipe_ctrl_state_t state;
    pipe_ctrl_state_t state_next;
    logic             load_use;

    hazard_detect u_hazard_detect (
        .idex_is_load  (idex_is_load),
        .idex_rd       (idex_rd),
        .ifid_rs1      (ifid_rs1),
        .ifid_rs2      (ifid_rs2),
        .ifid_uses_rs1 (ifid_uses_rs1),
        .ifid_uses_rs2 (ifid_uses_rs2),
        .load_use      (load_use)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    always_comb begin
        ifid_load   = 1'b1;
        idex_load   = 1'b1;
        exmem_load  = 1'b1;
        memwb_load  = 1'b1;
        ifid_sel    = load_ifid;
        idex_sel    = load_idex;
        exmem_sel   = load_exmem;
        memwb_sel   = load_memwb;
        pc_load     = imem_resp;
        pc_redirect = 1'b0;
        state_next  = state;

        if (rst) begin
            ifid_load  = 1'b0;
            idex_load  = 1'b0;
            exmem_load = 1'b0;
            memwb_load = 1'b0;
            ifid_sel   = use_old;
            idex_sel   = use_old;
            exmem_sel  = use_old;
            memwb_sel  = use_old;
            pc_load    = 1'b0;
            state_next = RUN;
        end else if (state == DISCARD) begin
            ifid_sel = load_invalid;
            pc_load  = 1'b0;
            if (dmem_stall) begin
                ifid_load  = 1'b0;
                idex_load  = 1'b0;
                exmem_load = 1'b0;
                memwb_load = 1'b0;
                idex_sel   = use_old;
                exmem_sel  = use_old;
                memwb_sel  = use_old;
            end
            // The stale response is consumed even while the data side is frozen.
            if (imem_resp) state_next = RUN;
        end else if (dmem_stall) begin
            ifid_load  = 1'b0;
            idex_load  = 1'b0;
            exmem_load = 1'b0;
            memwb_load = 1'b0;
            ifid_sel   = use_old;
            idex_sel   = use_old;
            exmem_sel  = use_old;
            memwb_sel  = use_old;
            pc_load    = 1'b0;
        end else if (ex_valid && ex_mispredict) begin
            ifid_sel    = load_invalid;
            idex_sel    = load_invalid;
            pc_load     = 1'b1;
            pc_redirect = 1'b1;
            if (imem_pending) state_next = DISCARD;
        end else if (load_use) begin
            ifid_load = 1'b0;
            ifid_sel  = use_old;
            idex_sel  = load_invalid;
            pc_load   = 1'b0;
        end else if (!imem_resp) begin
            ifid_sel = load_invalid;
            pc_load  = 1'b0;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic flush_honored;

    assign flush_honored = (state == RUN) && !dmem_stall && ex_valid && ex_mispredict;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= 32'd0;
            flush_count  <= 32'd0;
        end else begin
            if (dmem_stall || load_use) stall_cycles <= stall_cycles + 32'd1;
            if (flush_honored)          flush_count  <= flush_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipeline_control.sv
// Self-checking bench for pipeline_control: hand vectors, corner sequences and
// random stimulus against a rule-level reference model.
module tb_pipeline_control;
    import buffer_load_mux::*;

    typedef struct packed {
        logic       resp;
        logic       pend;
        logic       dstall;
        logic       exv;
        logic       mis;
        logic       isld;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
    } in_t;

    typedef struct packed {
        logic [3:0]  ld;   // {ifid, idex, exmem, memwb}
        buffer_sel_t s_ifid;
        buffer_sel_t s_idex;
        buffer_sel_t s_exmem;
        buffer_sel_t s_memwb;
        logic        pc;
        logic        redir;
    } out_t;

    typedef struct {
        string nm;
        in_t   i;
        out_t  e;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic imem_resp, imem_pending, dmem_stall, ex_valid, ex_mispredict, idex_is_load;
    logic [4:0] idex_rd, ifid_rs1, ifid_rs2;
    logic ifid_uses_rs1, ifid_uses_rs2;
    logic ifid_load, idex_load, exmem_load, memwb_load, pc_load, pc_redirect;
    buffer_sel_t ifid_sel, idex_sel, exmem_sel, memwb_sel;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    int nvec  = 0;
    int nfail = 0;
    bit discarding = 1'b0;   // model: a stale fetch response is still owed

    always #5 clk = ~clk;

    pipeline_control dut (
        .clk           (clk),
        .rst           (rst),
        .imem_resp     (imem_resp),
        .imem_pending  (imem_pending),
        .dmem_stall    (dmem_stall),
        .ex_valid      (ex_valid),
        .ex_mispredict (ex_mispredict),
        .idex_is_load  (idex_is_load),
        .idex_rd       (idex_rd),
        .ifid_rs1      (ifid_rs1),
        .ifid_rs2      (ifid_rs2),
        .ifid_uses_rs1 (ifid_uses_rs1),
        .ifid_uses_rs2 (ifid_uses_rs2),
        .ifid_load     (ifid_load),
        .idex_load     (idex_load),
        .exmem_load    (exmem_load),
        .memwb_load    (memwb_load),
        .ifid_sel      (ifid_sel),
        .idex_sel      (idex_sel),
        .exmem_sel     (exmem_sel),
        .memwb_sel     (memwb_sel),
        .pc_load       (pc_load),
        .pc_redirect   (pc_redirect)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
`endif
    );

    function automatic in_t mk_in(logic resp, logic pend, logic dstall, logic exv, logic mis,
                                  logic isld, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                  logic u1, logic u2);
        in_t v;
        v = '{resp, pend, dstall, exv, mis, isld, rd, rs1, rs2, u1, u2};
        return v;
    endfunction

    function automatic out_t mk_out(logic [3:0] ld, buffer_sel_t a, buffer_sel_t b,
                                    buffer_sel_t c, buffer_sel_t d, logic pc, logic redir);
        out_t v;
        v = '{ld, a, b, c, d, pc, redir};
        return v;
    endfunction

    // Reference: applies the event priority rules directly to the inputs.
    function automatic void model(input in_t i, input bit r, input bit disc,
                                  output out_t o, output bit nd);
        bit hazard;
        hazard = i.isld && i.rd != 0 && ((i.u1 && i.rs1 == i.rd) || (i.u2 && i.rs2 == i.rd));
        o  = mk_out(4'b1111, load_ifid, load_idex, load_exmem, load_memwb, i.resp, 1'b0);
        nd = disc;
        if (r) begin
            o  = mk_out(4'b0000, use_old, use_old, use_old, use_old, 1'b0, 1'b0);
            nd = 1'b0;
        end else if (disc) begin
            if (i.dstall) o = mk_out(4'b0000, load_invalid, use_old, use_old, use_old, 1'b0, 1'b0);
            else          o = mk_out(4'b1111, load_invalid, load_idex, load_exmem, load_memwb, 1'b0, 1'b0);
            if (i.resp) nd = 1'b0;
        end else if (i.dstall) begin
            o = mk_out(4'b0000, use_old, use_old, use_old, use_old, 1'b0, 1'b0);
        end else if (i.exv && i.mis) begin
            o  = mk_out(4'b1111, load_invalid, load_invalid, load_exmem, load_memwb, 1'b1, 1'b1);
            nd = i.pend;
        end else if (hazard) begin
            o = mk_out(4'b0111, use_old, load_invalid, load_exmem, load_memwb, 1'b0, 1'b0);
        end else if (!i.resp) begin
            o = mk_out(4'b1111, load_invalid, load_idex, load_exmem, load_memwb, 1'b0, 1'b0);
        end
    endfunction

    task automatic check(input string nm, input out_t act, input out_t ex);
        nvec++;
        if (act !== ex) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, ex);
        end
    endtask

    // Drive one cycle; compare against ex when use_exp, otherwise against the model.
    task automatic step(input string nm, input in_t i, input bit r, input bit use_exp, input out_t ex);
        out_t act, mo;
        bit nd;
        rst           = r;
        imem_resp     = i.resp;
        imem_pending  = i.pend;
        dmem_stall    = i.dstall;
        ex_valid      = i.exv;
        ex_mispredict = i.mis;
        idex_is_load  = i.isld;
        idex_rd       = i.rd;
        ifid_rs1      = i.rs1;
        ifid_rs2      = i.rs2;
        ifid_uses_rs1 = i.u1;
        ifid_uses_rs2 = i.u2;
        @(negedge clk);
        act = '{{ifid_load, idex_load, exmem_load, memwb_load},
                ifid_sel, idex_sel, exmem_sel, memwb_sel, pc_load, pc_redirect};
        model(i, r, discarding, mo, nd);
        check(nm, act, use_exp ? ex : mo);
        discarding = nd;
        @(posedge clk);
        #1;
    endtask

    out_t o_idle, o_rst, o_lu, o_fstall, o_mis, o_dst, o_disc;
    in_t  n_idle;
    vec_t tbl[$];

    initial begin
        o_idle   = mk_out(4'b1111, load_ifid, load_idex, load_exmem, load_memwb, 1'b1, 1'b0);
        o_rst    = mk_out(4'b0000, use_old, use_old, use_old, use_old, 1'b0, 1'b0);
        o_lu     = mk_out(4'b0111, use_old, load_invalid, load_exmem, load_memwb, 1'b0, 1'b0);
        o_fstall = mk_out(4'b1111, load_invalid, load_idex, load_exmem, load_memwb, 1'b0, 1'b0);
        o_mis    = mk_out(4'b1111, load_invalid, load_invalid, load_exmem, load_memwb, 1'b1, 1'b1);
        o_dst    = o_rst;
        o_disc   = o_fstall;
        n_idle   = mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        tbl.push_back('{"idle",          n_idle,                                      o_idle});
        tbl.push_back('{"loaduse_rs2",   mk_in(1, 0, 0, 0, 0, 1, 5, 3, 5, 1, 1),      o_lu});
        tbl.push_back('{"loaduse_rd0",   mk_in(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1),      o_idle});
        tbl.push_back('{"loaduse_rs1",   mk_in(1, 0, 0, 0, 0, 1, 9, 9, 2, 1, 0),      o_lu});
        tbl.push_back('{"rs1_unused",    mk_in(1, 0, 0, 0, 0, 1, 9, 9, 2, 0, 1),      o_idle});
        tbl.push_back('{"not_load",      mk_in(1, 0, 0, 0, 0, 0, 9, 9, 9, 1, 1),      o_idle});
        tbl.push_back('{"fetch_stall",   mk_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0),      o_fstall});
        tbl.push_back('{"mispred_nopnd", mk_in(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0),      o_mis});
        tbl.push_back('{"mispred_noval", mk_in(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0),      o_idle});
        tbl.push_back('{"dmem_stall",    mk_in(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0),      o_dst});
        tbl.push_back('{"lu_over_fetch", mk_in(0, 0, 0, 0, 0, 1, 4, 4, 0, 1, 0),      o_lu});
        tbl.push_back('{"mis_over_lu",   mk_in(0, 0, 0, 1, 1, 1, 4, 4, 0, 1, 0),      o_mis});

        step("reset", n_idle, 1'b1, 1'b1, o_rst);
        foreach (tbl[k]) step(tbl[k].nm, tbl[k].i, 1'b0, 1'b1, tbl[k].e);

        // Mispredict with a fetch outstanding: redirect, 4 DISCARD cycles, then RUN.
        step("mis_pend_c0", mk_in(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, o_mis);
        step("discard_c1",  mk_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, o_disc);
        step("discard_c2",  mk_in(0, 1, 0, 1, 1, 1, 3, 3, 0, 1, 0), 1'b0, 1'b1, o_disc);
        step("discard_c3",  mk_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, o_disc);
        step("discard_c4",  n_idle,                                 1'b0, 1'b1, o_disc);
        step("run_c5",      n_idle,                                 1'b0, 1'b1, o_idle);

        // dmem_stall masks a pending mispredict and load-use for 3 cycles.
        for (int c = 0; c < 3; c++)
            step("dstall_hold", mk_in(1, 0, 1, 1, 1, 1, 7, 7, 0, 1, 0), 1'b0, 1'b1, o_dst);
        step("dstall_release", mk_in(1, 0, 0, 1, 1, 1, 7, 7, 0, 1, 0), 1'b0, 1'b1, o_mis);
        step("after_release",  n_idle,                                 1'b0, 1'b1, o_idle);

        // Reset while in DISCARD returns straight to RUN.
        step("enter_discard", mk_in(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, o_mis);
        step("in_discard",    mk_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, o_disc);
        step("rst_discard",   mk_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1, o_rst);
        step("run_after_rst", n_idle,                                 1'b0, 1'b1, o_idle);

`ifdef PIPE_CTRL_PERF_EN
        step("perf_reset", n_idle, 1'b1, 1'b1, o_rst);
        step("perf_mis1", mk_in(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, o_mis);
        step("perf_idle", n_idle, 1'b0, 1'b1, o_idle);
        step("perf_mis2", mk_in(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, o_mis);
        for (int c = 0; c < 4; c++)
            step("perf_stall", mk_in(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, o_dst);
        nvec++;
        if (flush_count !== 32'd2) begin
            nfail++;
            $display("FAIL flush_count: got %0d expected 2", flush_count);
        end
        nvec++;
        if (stall_cycles !== 32'd4) begin
            nfail++;
            $display("FAIL stall_cycles: got %0d expected 4", stall_cycles);
        end
`endif

        for (int n = 0; n < 600; n++) begin
            in_t ri;
            bit  rr;
            ri = mk_in(($urandom % 4) != 0, $urandom % 2, ($urandom % 5) == 0,
                       ($urandom % 2) != 0, ($urandom % 3) == 0, $urandom % 2,
                       5'($urandom % 4), 5'($urandom % 4), 5'($urandom % 4),
                       $urandom % 2, $urandom % 2);
            rr = ($urandom % 40) == 0;
            step("random", ri, rr, 1'b0, o_idle);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
